redirect_arbiter: RTL and testbench

Sequencing controller for fetch redirects in the out-of-order core. It collects redirect requests from three sources: the decode-stage JAL redirect, the execute-stage branch mispredict, and the commit-stage exception/flush. It selects by priority and ROB age, holds the winner until fetch accepts it, and emits flush pulses. After a backend-level redirect it enforces a squash window so that stale wrong-path requests are discarded.

---
 rtl/redirect_arbiter_if.sv | 39 +++
 rtl/redirect_arbiter.sv | 172 +++++++++++++++++
 tb/tb_redirect_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/redirect_arbiter_if.sv
// Redirect request/response bundle between the redirect sources, fetch and
// the redirect arbiter. The arbiter sits on the slave side.
interface redirect_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             io_Dec_Valid;
    logic [31:0]      io_Dec_Target;
    logic             io_Exe_Valid;
    logic [31:0]      io_Exe_Target;
    logic [TAG_W-1:0] io_Exe_Tag;
    logic             io_Cmt_Valid;
    logic [31:0]      io_Cmt_Target;
    logic [TAG_W-1:0] io_Rob_Head;
    logic             io_Fetch_Ready;
    logic             io_Redirect_Valid;
    logic [31:0]      io_Redirect_Target;
    logic [1:0]       io_Redirect_Source;
    logic             io_Flush_Frontend;
    logic             io_Flush_Backend;
    logic [TAG_W-1:0] io_Flush_Tag;

    modport master (
        output io_Dec_Valid, io_Dec_Target,
        output io_Exe_Valid, io_Exe_Target, io_Exe_Tag,
        output io_Cmt_Valid, io_Cmt_Target,
        output io_Rob_Head, io_Fetch_Ready,
        input  io_Redirect_Valid, io_Redirect_Target, io_Redirect_Source,
        input  io_Flush_Frontend, io_Flush_Backend, io_Flush_Tag
    );

    modport slave (
        input  io_Dec_Valid, io_Dec_Target,
        input  io_Exe_Valid, io_Exe_Target, io_Exe_Tag,
        input  io_Cmt_Valid, io_Cmt_Target,
        input  io_Rob_Head, io_Fetch_Ready,
        output io_Redirect_Valid, io_Redirect_Target, io_Redirect_Source,
        output io_Flush_Frontend, io_Flush_Backend, io_Flush_Tag
    );
endinterface

// File: rtl/redirect_arbiter.sv
// Fetch redirect arbiter: picks one of decode/execute/commit redirects by
// priority and ROB age, holds it until fetch accepts, pulses flushes, and
// discards stale wrong-path requests during a post-redirect squash window.
//
// state  | meaning
// IDLE   | nothing held, any request is captured
// PEND   | request held and presented to fetch
// SQUASH | backend redirect issued, stale requests dropped
module redirect_arbiter #(
    parameter int TAG_W         = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input logic                clock,
    input logic                reset,
    redirect_arbiter_if.slave  bus
);
    localparam int CNT_W = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_DEC  = 2'd1;
    localparam logic [1:0] SRC_EXE  = 2'd2;
    localparam logic [1:0] SRC_CMT  = 2'd3;

    typedef enum logic [1:0] {IDLE, PEND, SQUASH} state_t;

    state_t           state_q, state_d;
    logic [1:0]       hold_src_q, hold_src_d;
    logic [31:0]      hold_target_q, hold_target_d;
    logic [TAG_W-1:0] hold_tag_q, hold_tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_src_q, last_src_d;
    logic [TAG_W-1:0] last_tag_q, last_tag_d;

    logic [1:0]       win_src;
    logic [31:0]      win_target;
    logic [TAG_W-1:0] win_tag;
    logic             accept_pend;
    logic             accept_squash;
    logic             pend;

    // Age is distance from the ROB head modulo the tag space; equal is not older.
    function automatic logic is_older(input logic [TAG_W-1:0] a,
                                      input logic [TAG_W-1:0] b,
                                      input logic [TAG_W-1:0] head);
        logic [TAG_W-1:0] age_a;
        logic [TAG_W-1:0] age_b;
        age_a = a - head;
        age_b = b - head;
        return age_a < age_b;
    endfunction

    // Single winner of the cycle by fixed priority Cmt > Exe > Dec.
    always_comb begin
        win_src    = SRC_NONE;
        win_target = '0;
        win_tag    = '0;
        if (bus.io_Cmt_Valid) begin
            win_src    = SRC_CMT;
            win_target = bus.io_Cmt_Target;
        end else if (bus.io_Exe_Valid) begin
            win_src    = SRC_EXE;
            win_target = bus.io_Exe_Target;
            win_tag    = bus.io_Exe_Tag;
        end else if (bus.io_Dec_Valid) begin
            win_src    = SRC_DEC;
            win_target = bus.io_Dec_Target;
        end
    end

    // Acceptance rules; in PEND the held request is also the one being issued
    // on a handshake, so both cases share one rule.
    always_comb begin
        accept_pend = (win_src == SRC_CMT) ||
                      ((win_src == SRC_EXE) &&
                       ((hold_src_q == SRC_DEC) ||
                        ((hold_src_q == SRC_EXE) &&
                         is_older(win_tag, hold_tag_q, bus.io_Rob_Head))));
        accept_squash = (win_src == SRC_CMT) ||
                        ((win_src == SRC_EXE) && (last_src_q == SRC_EXE) &&
                         is_older(win_tag, last_tag_q, bus.io_Rob_Head));
    end

    // Next-state, hold register, squash counter and last-issued bookkeeping.
    always_comb begin
        state_d       = state_q;
        hold_src_d    = hold_src_q;
        hold_target_d = hold_target_q;
        hold_tag_d    = hold_tag_q;
        cnt_d         = cnt_q;
        last_src_d    = last_src_q;
        last_tag_d    = last_tag_q;
        case (state_q)
            IDLE: begin
                if (win_src != SRC_NONE) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (bus.io_Fetch_Ready) begin
                    last_src_d = hold_src_q;
                    last_tag_d = hold_tag_q;
                    if (hold_src_q == SRC_DEC) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SQUASH;
                        cnt_d   = CNT_W'(SQUASH_CYCLES);
                    end
                    hold_src_d    = SRC_NONE;
                    hold_target_d = '0;
                    hold_tag_d    = '0;
                end
                if (accept_pend) begin
                    state_d = PEND;
                    cnt_d   = '0;
                end
            end
            SQUASH: begin
                if (accept_squash) begin
                    state_d = PEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (((state_q == IDLE) && (win_src != SRC_NONE)) ||
            ((state_q == PEND) && accept_pend) ||
            ((state_q == SQUASH) && accept_squash)) begin
            hold_src_d    = win_src;
            hold_target_d = win_target;
            hold_tag_d    = win_tag;
        end
    end

    // State and hold registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_src_q    <= SRC_NONE;
            hold_target_q <= '0;
            hold_tag_q    <= '0;
            cnt_q         <= '0;
            last_src_q    <= SRC_NONE;
            last_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            hold_src_q    <= hold_src_d;
            hold_target_q <= hold_target_d;
            hold_tag_q    <= hold_tag_d;
            cnt_q         <= cnt_d;
            last_src_q    <= last_src_d;
            last_tag_q    <= last_tag_d;
        end
    end

    // Outputs decode from state and hold register only; reset masks them so a
    // reset landing on a handshake cycle cannot emit a flush.
    assign pend                   = (state_q == PEND) && !reset;
    assign bus.io_Redirect_Valid  = pend;
    assign bus.io_Redirect_Target = pend ? hold_target_q : 32'd0;
    assign bus.io_Redirect_Source = pend ? hold_src_q : SRC_NONE;
    assign bus.io_Flush_Tag       = pend ? hold_tag_q : '0;
    assign bus.io_Flush_Frontend  = pend && bus.io_Fetch_Ready;
    assign bus.io_Flush_Backend   = pend && bus.io_Fetch_Ready && hold_src_q[1];
endmodule

// File: tb/tb_redirect_arbiter.sv
// Directed bench for redirect_arbiter: a continuous table of per-cycle
// inputs with expected outputs for the same cycle, then a hand-written
// squash-window exit timing sequence.
module tb_redirect_arbiter;
    localparam int TAG_W = 4;
    localparam int SQ    = 2;

    logic clock;
    logic reset;

    redirect_arbiter_if #(.TAG_W(TAG_W)) bus ();

    redirect_arbiter #(.TAG_W(TAG_W), .SQUASH_CYCLES(SQ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [31:0] dt;
        logic        ev;
        logic [31:0] et;
        logic [3:0]  etag;
        logic        cv;
        logic [31:0] ct;
        logic [3:0]  head;
        logic        rdy;
        logic        x_v;
        logic [31:0] x_t;
        logic [1:0]  x_src;
        logic        x_ff;
        logic        x_fb;
        logic [3:0]  x_tag;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(
        input logic rst, input logic dv, input logic [31:0] dt,
        input logic ev, input logic [31:0] et, input logic [3:0] etag,
        input logic cv, input logic [31:0] ct, input logic [3:0] head,
        input logic rdy,
        input logic x_v, input logic [31:0] x_t, input logic [1:0] x_src,
        input logic x_ff, input logic x_fb, input logic [3:0] x_tag);
        vec_t v;
        v.rst = rst; v.dv = dv; v.dt = dt; v.ev = ev; v.et = et; v.etag = etag;
        v.cv = cv; v.ct = ct; v.head = head; v.rdy = rdy;
        v.x_v = x_v; v.x_t = x_t; v.x_src = x_src; v.x_ff = x_ff;
        v.x_fb = x_fb; v.x_tag = x_tag;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic dv, input logic [31:0] dt,
                         input logic ev, input logic [31:0] et, input logic [3:0] etag,
                         input logic cv, input logic [31:0] ct, input logic [3:0] head,
                         input logic rdy);
        @(negedge clock);
        reset              = rst;
        bus.io_Dec_Valid   = dv;
        bus.io_Dec_Target  = dt;
        bus.io_Exe_Valid   = ev;
        bus.io_Exe_Target  = et;
        bus.io_Exe_Tag     = etag;
        bus.io_Cmt_Valid   = cv;
        bus.io_Cmt_Target  = ct;
        bus.io_Rob_Head    = head;
        bus.io_Fetch_Ready = rdy;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.rst, v.dv, v.dt, v.ev, v.et, v.etag, v.cv, v.ct, v.head, v.rdy);
        #1;
        n_vec++;
        if (bus.io_Redirect_Valid !== v.x_v || bus.io_Redirect_Target !== v.x_t ||
            bus.io_Redirect_Source !== v.x_src || bus.io_Flush_Frontend !== v.x_ff ||
            bus.io_Flush_Backend !== v.x_fb || bus.io_Flush_Tag !== v.x_tag) begin
            n_bad++;
            $display("FAIL vec%0d: got v=%b t=%h src=%0d ff=%b fb=%b tag=%0d, want v=%b t=%h src=%0d ff=%b fb=%b tag=%0d",
                     idx, bus.io_Redirect_Valid, bus.io_Redirect_Target,
                     bus.io_Redirect_Source, bus.io_Flush_Frontend,
                     bus.io_Flush_Backend, bus.io_Flush_Tag,
                     v.x_v, v.x_t, v.x_src, v.x_ff, v.x_fb, v.x_tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k_hit;
        logic [31:0] t_hit;
        n_vec = 0;
        n_bad = 0;

        //          rst dv dt       ev et       tg cv ct       hd rdy | v t        src ff fb tag
        // reset state
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        // basic decode redirect
        vecs.push_back(mk(0, 1, 'h1000,  0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  1, 'h1000,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        // simultaneous sources: commit wins, then two squash cycles
        vecs.push_back(mk(0, 1, 'h1000,  1, 'h2000,  3, 1, 'h8000,  0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  1, 'h8000,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  1, 'h8000,  3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h1111,  0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        // backpressure replacement, head 2
        vecs.push_back(mk(0, 0, 0,       1, 'h5000,  5, 0, 0,       2, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h4000,  4, 0, 0,       2, 0,  1, 'h5000,  2, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0,       1, 'h6000,  6, 0, 0,       2, 0,  1, 'h4000,  2, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0,       1, 'h7000,  4, 0, 0,       2, 0,  1, 'h4000,  2, 0, 0, 4));
        vecs.push_back(mk(0, 1, 'h1234,  0, 0,       0, 0, 0,       2, 0,  1, 'h4000,  2, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       2, 1,  1, 'h4000,  2, 1, 1, 4));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       2, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       2, 0,  0, 0,       0, 0, 0, 0));
        // tag wrap, head 14
        vecs.push_back(mk(0, 0, 0,       1, 'hA000,  1, 0, 0,      14, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'hB000, 15, 0, 0,      14, 0,  1, 'hA000,  2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,      14, 0,  1, 'hB000,  2, 0, 0, 15));
        vecs.push_back(mk(0, 0, 0,       1, 'hC000,  1, 0, 0,      14, 0,  1, 'hB000,  2, 0, 0, 15));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,      14, 1,  1, 'hB000,  2, 1, 1, 15));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        // squash window drops decode; decode right after window is taken
        vecs.push_back(mk(0, 0, 0,       1, 'h7000,  7, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hD000,  0, 0,       0, 0, 0,       0, 1,  1, 'h7000,  2, 1, 1, 7));
        vecs.push_back(mk(0, 1, 'hD001,  0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hD002,  0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'hD003,  0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  1, 'hD003,  1, 1, 0, 0));
        // squash window: younger exe dropped, older exe captured
        vecs.push_back(mk(0, 1, 'h5555,  1, 'h7000,  7, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  1, 'h7000,  2, 1, 1, 7));
        vecs.push_back(mk(0, 0, 0,       1, 'h8000,  8, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h6000,  6, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  1, 'h6000,  2, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  1, 'h6000,  2, 1, 1, 6));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        // captures in the handshake cycle, judged against the issued request
        vecs.push_back(mk(0, 1, 'h1000,  0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h2000,  3, 0, 0,       0, 1,  1, 'h1000,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  1, 'h2000,  2, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1, 'h9000,  0, 1,  1, 'h2000,  2, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0,       1, 'h3333,  0, 0, 0,       0, 0,  1, 'h9000,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h3000,  1, 0, 0,       0, 1,  1, 'h9000,  3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1, 'hA0A0,  0, 0,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  1, 'hA0A0,  3, 0, 0, 0));
        // reset mid-PEND with fetch ready: no pulse, everything cleared
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0, 0,       0, 1,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 1,  0, 0,       0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0, 0,       0, 0,  0, 0,       0, 0, 0, 0));

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

        // Squash exit timing: decode held high every cycle after an Exe
        // handshake must first show up as a redirect SQ+2 cycles later.
        drive(0, 0, 0, 1, 'h55, 5, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        k_hit = 0;
        t_hit = '0;
        for (int k = 1; k <= 10; k++) begin
            drive(0, 1, 'hE000, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (bus.io_Redirect_Valid === 1'b1) begin
                k_hit = k;
                t_hit = bus.io_Redirect_Target;
                break;
            end
        end
        n_vec++;
        if (k_hit != SQ + 2) begin
            n_bad++;
            $display("FAIL squash_exit: redirect after %0d cycles, want %0d", k_hit, SQ + 2);
        end
        n_vec++;
        if (t_hit !== 32'hE000) begin
            n_bad++;
            $display("FAIL squash_exit_target: got %h, want %h", t_hit, 32'hE000);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        n_vec++;
        if (bus.io_Flush_Frontend !== 1'b1 || bus.io_Flush_Backend !== 1'b0) begin
            n_bad++;
            $display("FAIL squash_exit_flush: ff=%b fb=%b, want ff=1 fb=0",
                     bus.io_Flush_Frontend, bus.io_Flush_Backend);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (bus.io_Redirect_Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL squash_exit_idle: valid=%b, want 0", bus.io_Redirect_Valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
